// File: rtl/led_step_ctrl.sv
// LED step controller: debounced run/stop and direction buttons plus a
// SPEED-scaled prescaler that emits one-cycle step strobes while running.
module led_step_ctrl #(
  parameter int DIV    = 50000000,
  parameter int DB_CNT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTN_SS,
  input  logic       BTN_MODE,
  input  logic [1:0] SPEED,
  output logic       SS,
  output logic       MODE,
  output logic       RUN
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(DB_CNT);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CNT - 1);
  localparam logic [31:0]   DIV_U   = 32'(DIV);

  // state   | meaning
  // ST_STOP | prescaler held at 0, no strobes
  // ST_RUN  | prescaler counting, strobe on each terminal count
  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          w_btn;
  logic [1:0]          r_sync1, r_sync2, r_db;
  logic [1:0][DW-1:0]  r_dcnt;
  logic [1:0]          w_upd, w_press;
  logic [PW-1:0]       r_pcnt, w_pcnt_nxt;
  logic                r_ss, w_ss_nxt;
  logic                r_mode, w_mode_nxt;
  logic [31:0]         w_period, w_term;

  // Index 0 is run/stop, index 1 is direction.
  assign w_btn = {BTN_MODE, BTN_SS};

  always_comb begin
    w_upd   = '0;
    w_press = '0;
    for (int i = 0; i < 2; i++) begin
      w_upd[i]   = (r_sync2[i] != r_db[i]) && (r_dcnt[i] == DB_LAST);
      w_press[i] = w_upd[i] && r_sync2[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dcnt[i] <= '0;
        end else if (w_upd[i]) begin
          r_db[i]   <= r_sync2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  // Period never drops below 2 so a strobe is always followed by a low cycle.
  always_comb begin
    w_period = DIV_U >> SPEED;
    if (w_period < 32'd2) w_period = 32'd2;
    w_term = w_period - 32'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_ss_nxt    = 1'b0;
    w_mode_nxt  = r_mode ^ w_press[1];
    case (r_state)
      ST_STOP: begin
        w_pcnt_nxt = '0;
        if (w_press[0]) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // >= so a SPEED change that shrinks the period wraps on the next edge
        if (32'(r_pcnt) >= w_term) begin
          w_pcnt_nxt = '0;
          w_ss_nxt   = 1'b1;
        end else begin
          w_pcnt_nxt = r_pcnt + 1'b1;
        end
        if (w_press[0]) w_state_nxt = ST_STOP;
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_STOP;
      r_pcnt  <= '0;
      r_ss    <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_ss    <= w_ss_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  assign SS   = r_ss;
  assign MODE = r_mode;
  assign RUN  = (r_state == ST_RUN);

endmodule

// File: tb/tb_led_step_ctrl.sv
// Bench for led_step_ctrl (DIV=8, DB_CNT=4): directed scenarios plus random
// button/speed/reset traffic, compared every cycle against an event-level model.
module tb_led_step_ctrl;

  localparam int DIV    = 8;
  localparam int DB_CNT = 4;

  logic       clk;
  logic       reset;
  logic       BTN_SS;
  logic       BTN_MODE;
  logic [1:0] SPEED;
  logic       SS;
  logic       MODE;
  logic       RUN;

  int checks = 0;
  int errors = 0;
  int ss_hi  = 0;

  led_step_ctrl #(.DIV(DIV), .DB_CNT(DB_CNT)) dut (
    .clk     (clk),
    .reset   (reset),
    .BTN_SS  (BTN_SS),
    .BTN_MODE(BTN_MODE),
    .SPEED   (SPEED),
    .SS      (SS),
    .MODE    (MODE),
    .RUN     (RUN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a button level is accepted once the synchronized level
  // (raw level two edges old) has disagreed with the accepted one for DB_CNT
  // consecutive edges. Steps are counted as elapsed cycles against P.
  int m_k;
  int m_el;
  int m_streak [2];
  bit m_db     [2];
  bit raw_log  [2][4];
  bit m_run, m_mode, m_ss;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k = 0; m_el = 0; m_run = 0; m_mode = 0; m_ss = 0;
      for (int b = 0; b < 2; b++) begin
        m_db[b] = 0;
        m_streak[b] = 0;
        for (int j = 0; j < 4; j++) raw_log[b][j] = 0;
      end
    end else begin
      bit raw [2];
      bit press [2];
      bit s2;
      int p;
      raw[0] = BTN_SS;
      raw[1] = BTN_MODE;
      for (int b = 0; b < 2; b++) begin
        s2 = (m_k >= 2) ? raw_log[b][(m_k - 2) % 4] : 1'b0;
        raw_log[b][m_k % 4] = raw[b];
        press[b] = 0;
        if (s2 == m_db[b]) m_streak[b] = 0;
        else begin
          m_streak[b]++;
          if (m_streak[b] == DB_CNT) begin
            m_db[b] = s2;
            m_streak[b] = 0;
            press[b] = s2;
          end
        end
      end
      p = DIV / (1 << SPEED);
      if (p < 2) p = 2;
      if (!m_run) begin m_ss = 0; m_el = 0; end
      else if (m_el + 1 >= p) begin m_ss = 1; m_el = 0; end
      else begin m_ss = 0; m_el++; end
      if (press[0]) m_run = !m_run;
      if (press[1]) m_mode = !m_mode;
      m_k++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_ss", SS, m_ss);
    chk("model_mode", MODE, m_mode);
    chk("model_run", RUN, m_run);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (SS === 1'b1) ss_hi++;
      check_model();
    end
  endtask

  initial begin
    int found;
    int ss_start;
    reset = 1'b1; BTN_SS = 1'b0; BTN_MODE = 1'b0; SPEED = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ss", SS, 0);
    chk("reset_mode", MODE, 0);
    chk("reset_run", RUN, 0);
    reset = 1'b0;

    // Held press: RUN at edge 6, strobes at 14, 22, 30.
    BTN_SS = 1'b1;
    tick(5);  chk("run_edge5", RUN, 0);
    tick(1);  chk("run_edge6", RUN, 1);
    tick(7);  chk("ss_edge13", SS, 0);
    tick(1);  chk("ss_edge14", SS, 1);
    tick(1);  chk("ss_edge15", SS, 0);
    tick(7);  chk("ss_edge22", SS, 1);
    tick(8);  chk("ss_edge30", SS, 1);

    // Speed change mid-count: pcnt=6 at edge 36.
    tick(6);  SPEED = 2'd2;
    tick(1);  chk("fast_edge37", SS, 1);
    tick(1);  chk("fast_edge38", SS, 0);
    tick(1);  chk("fast_edge39", SS, 1);
    SPEED = 2'd3;
    tick(1);  chk("clamp_edge40", SS, 0);
    tick(1);  chk("clamp_edge41", SS, 1);

    // Direction press while running.
    SPEED = 2'd1;
    BTN_MODE = 1'b1;
    tick(5);  chk("mode_before", MODE, 0);
    tick(1);  chk("mode_after", MODE, 1);
    BTN_MODE = 1'b0;
    tick(12);

    // Stop press coincident with a terminal count.
    BTN_SS = 1'b0;
    tick(10); chk("release_no_effect", RUN, 1);
    SPEED = 2'd0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (SS === 1'b1) found = 1;
    end
    chk("ss_found", found, 1);
    tick(2);  BTN_SS = 1'b1;
    tick(5);  chk("stop_pre_ss", SS, 0);
              chk("stop_pre_run", RUN, 1);
    tick(1);  chk("stop_last_ss", SS, 1);
              chk("stop_run", RUN, 0);
    ss_start = ss_hi;
    tick(20); chk("stopped_no_ss", ss_hi - ss_start, 0);

    // Glitches of 1, 2 and 3 cycles are rejected.
    BTN_SS = 1'b0;
    tick(10);
    ss_start = ss_hi;
    BTN_SS = 1'b1; tick(1); BTN_SS = 1'b0; tick(4);
    BTN_SS = 1'b1; tick(2); BTN_SS = 1'b0; tick(4);
    BTN_SS = 1'b1; tick(3); BTN_SS = 1'b0; tick(12);
    chk("glitch_run", RUN, 0);
    chk("glitch_ss", ss_hi - ss_start, 0);

    // Reset during debounce, then during a run.
    BTN_SS = 1'b1;
    tick(3);
    reset = 1'b1; #1;
    chk("rst_db_mode", MODE, 0);
    chk("rst_db_run", RUN, 0);
    tick(2);
    reset = 1'b0;
    tick(5);  chk("rst_db_run5", RUN, 0);
    tick(1);  chk("rst_db_run6", RUN, 1);
    tick(3);
    reset = 1'b1; #1;
    chk("rst_run_run", RUN, 0);
    chk("rst_run_ss", SS, 0);
    tick(2);
    reset = 1'b0;
    tick(5);  chk("rst_run_run5", RUN, 0);
    tick(1);  chk("rst_run_run6", RUN, 1);

    // Simultaneous presses both take effect.
    BTN_SS = 1'b0;
    tick(10);
    BTN_SS = 1'b1; BTN_MODE = 1'b1;
    tick(5);  chk("both_pre_run", RUN, 1);
              chk("both_pre_mode", MODE, 0);
    tick(1);  chk("both_run", RUN, 0);
              chk("both_mode", MODE, 1);
    tick(8);

    // Random traffic.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 9) == 0) BTN_SS = ~BTN_SS;
      if ($urandom_range(0, 11) == 0) BTN_MODE = ~BTN_MODE;
      if ($urandom_range(0, 39) == 0) SPEED = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1; #1;
        chk("rand_rst_run", RUN, 0);
        tick(2);
        reset = 1'b0;
      end
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
